// File: rtl/rr_pri_enc.sv
// rr_pri_enc: registered priority encoder with fixed or round-robin priority.
//   Picks one active request from in[], registers its binary index (out) and
//   one-hot grant under a valid/ready handshake. In round-robin mode the
//   search start (ptr) moves just below the granted index on each handshake.
// Ports:
//   clk        clock
//   reset_     synchronous, active-low reset
//   in         request vector, active level ACT
//   flush      active-high, discards the held result
//   out_ready  active-high, consumer takes the held result
//   out_valid  held result present, active level ACT
//   out        binary index of the granted request
//   grant      one-hot grant, active level ACT
//   ptr        current search start index

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module rr_pri_enc #(
    parameter int   IN  = 32,
    parameter logic ACT = `High,
    parameter int   RR  = 1,
    localparam int  OUT = $clog2(IN)
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic [IN-1:0]  in,
    input  logic           flush,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [OUT-1:0] out,
    output logic [IN-1:0]  grant,
    output logic [OUT-1:0] ptr
);

    localparam logic [OUT-1:0] LAST = OUT'(IN - 1);

    logic [IN-1:0]  req;
    logic           valid_q;
    logic [OUT-1:0] out_q;
    logic [IN-1:0]  grant_q;
    logic [OUT-1:0] ptr_q;
    logic [OUT-1:0] ptr_d;
    logic           hs;
    logic           load;
    logic           hit_lo;
    logic           hit_hi;
    logic [OUT-1:0] sel_lo;
    logic [OUT-1:0] sel_hi;
    logic [OUT-1:0] sel;
    logic           any;
    logic [IN-1:0]  onehot;

    // Work internally in active-high terms.
    assign req  = ACT ? in : ~in;
    assign hs   = valid_q && out_ready;
    assign load = !valid_q || out_ready;

    // The selection made on a handshake edge must already use the advanced
    // pointer, otherwise the just-granted index would win a second time.
    always_comb begin
        ptr_d = ptr_q;
        if (RR == 0) begin
            ptr_d = LAST;
        end else if (hs) begin
            ptr_d = (out_q == '0) ? LAST : out_q - 1'b1;
        end
    end

    // Descending wrap-around search from ptr_d, done as two passes: the
    // highest active index at or below ptr_d, else the highest active index
    // overall (which then lies above ptr_d). Avoids a modulo rotation, so
    // non-power-of-two IN needs no special case.
    always_comb begin
        hit_lo = 1'b0;
        hit_hi = 1'b0;
        sel_lo = '0;
        sel_hi = '0;
        for (int unsigned i = 0; i < IN; i++) begin
            if (req[i]) begin
                hit_hi = 1'b1;
                sel_hi = OUT'(i);
                if (OUT'(i) <= ptr_d) begin
                    hit_lo = 1'b1;
                    sel_lo = OUT'(i);
                end
            end
        end
        any    = hit_hi;
        sel    = hit_lo ? sel_lo : sel_hi;
        onehot = '0;
        if (any) begin
            onehot[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            grant_q <= '0;
            ptr_q   <= LAST;
        end else begin
            ptr_q <= ptr_d;
            if (flush) begin
                valid_q <= 1'b0;
                grant_q <= '0;
            end else if (load) begin
                valid_q <= any;
                grant_q <= onehot;
                if (any) begin
                    out_q <= sel;
                end
            end
        end
    end

    assign out_valid = valid_q ? ACT : ~ACT;
    assign out       = out_q;
    assign grant     = ACT ? grant_q : ~grant_q;
    assign ptr       = ptr_q;

endmodule
